multdiv_unit: RTL and testbench

Sequential signed 32-bit multiply/divide unit that sits beside the single-cycle add/sub ALU in the execute stage. It accepts the same operand pair, is started by a one-cycle `ctrl_MULT` or `ctrl_DIV` pulse and iterates one bit per cycle. It returns a 32-bit result with an exception flag and a one-cycle ready pulse. The pipeline stalls on it for multi-cycle operations the combinational ALU cannot perform.

---
 rtl/multdiv_pkg.sv | 23 ++
 rtl/multdiv_step.sv | 38 +++
 rtl/multdiv_unit.sv | 137 +++++++++++++
 tb/tb_multdiv_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// ============================================================================
// Module      : multdiv_pkg
// Description : Shared constants and FSM state type for the multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multdiv_pkg;

    localparam int          ITERS   = 32;
    localparam int          CNT_W   = 6;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/multdiv_step.sv
// ============================================================================
// Module      : multdiv_step
// Description : One iteration of shift-add multiply or restoring divide.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multdiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               i_div_mode,
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_rem,
    input  logic [WIDTH-1:0]   i_opnd,
    output logic [2*WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0]   o_rem
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_trial;

    always_comb begin
        w_sum     = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : {(WIDTH+1){1'b0}});
        w_shifted = {i_rem, i_acc[WIDTH-1]};
        w_trial   = w_shifted - {1'b0, i_opnd};
        o_acc     = {w_sum, i_acc[WIDTH-1:1]};
        o_rem     = i_rem;
        // Divide keeps the quotient in the low half; the remainder stays below the divisor.
        if (i_div_mode) begin
            o_acc = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-2:0], ~w_trial[WIDTH]};
            o_rem = w_trial[WIDTH] ? w_shifted[WIDTH-1:0] : w_trial[WIDTH-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/multdiv_unit.sv
// ============================================================================
// Module      : multdiv_unit
// Description : Sequential signed 32-bit multiply/divide, one bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    state_t               r_state;
    state_t               w_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_opnd;
    logic                 r_sign;
    logic                 r_div;
    logic [WIDTH-1:0]     r_result;
    logic                 r_exc;
    logic                 r_rdy;

    logic                 w_start;
    logic                 w_start_div;
    logic                 w_last;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [2*WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]     w_rem_nxt;
    logic [2*WIDTH-1:0]   w_prod_s;
    logic [WIDTH-1:0]     w_quot;
    logic                 w_mul_ovf;
    logic                 w_div_zero;
    logic                 w_div_ovf;

    assign w_start     = ctrl_MULT | ctrl_DIV;
    assign w_start_div = ctrl_DIV & ~ctrl_MULT;
    assign w_last      = (r_cnt == CNT_W'(ITERS - 1));
    assign w_mag_a     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign w_mag_b     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // Sign is applied only after the magnitude iteration completes.
    assign w_prod_s   = r_sign ? -r_acc : r_acc;
    assign w_quot     = r_sign ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_mul_ovf  = ~(&w_prod_s[2*WIDTH-1:WIDTH-1]) & (|w_prod_s[2*WIDTH-1:WIDTH-1]);
    assign w_div_zero = (r_opnd == '0);
    assign w_div_ovf  = ~r_sign & (r_acc[WIDTH-1:0] == INT_MIN);

    multdiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_div_mode (r_div),
        .i_acc      (r_acc),
        .i_rem      (r_rem),
        .i_opnd     (r_opnd),
        .o_acc      (w_acc_nxt),
        .o_rem      (w_rem_nxt)
    );

    always_comb begin
        w_next = r_state;
        if (w_start) begin
            w_next = ctrl_MULT ? MUL : DIV;
        end else begin
            case (r_state)
                MUL, DIV: if (w_last) w_next = FIX;
                FIX:      w_next = IDLE;
                default:  w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_opnd   <= '0;
            r_sign   <= 1'b0;
            r_div    <= 1'b0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            if (w_start) begin
                r_cnt  <= '0;
                r_sign <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                r_div  <= w_start_div;
                r_acc  <= {{WIDTH{1'b0}}, (w_start_div ? w_mag_a : w_mag_b)};
                r_opnd <= w_start_div ? w_mag_b : w_mag_a;
                r_rem  <= '0;
            end else if (r_state == MUL || r_state == DIV) begin
                r_acc <= w_acc_nxt;
                r_rem <= w_rem_nxt;
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (r_state == FIX) begin
                r_rdy <= 1'b1;
                if (r_div) begin
                    r_result <= w_div_zero ? '0 : (w_div_ovf ? INT_MIN : w_quot);
                    r_exc    <= w_div_zero | w_div_ovf;
                end else begin
                    r_result <= w_prod_s[WIDTH-1:0];
                    r_exc    <= w_mul_ovf;
                end
            end
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;

endmodule

`default_nettype wire

// File: tb/tb_multdiv_unit.sv
// ============================================================================
// Module      : tb_multdiv_unit
// Description : Directed self-checking bench for multdiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multdiv_unit;

    logic        clock;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int checks = 0;
    int errors = 0;

    multdiv_unit #(
        .WIDTH (32)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Start pulse sampled at the edge after the drive; returns 1 time unit past that edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic m, input logic d);
        @(posedge clock); #1;
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    task automatic wait_rdy(output int lat);
        bit found;
        found = 1'b0;
        lat   = -1;
        for (int i = 1; i <= 40 && !found; i++) begin
            @(posedge clock); #1;
            if (data_resultRDY) begin
                lat   = i;
                found = 1'b1;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (data_result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want %h", data_result, 32'h0); end
        checks++; if (data_exception !== 1'b0) begin errors++; $display("FAIL reset_exc got %b want 0", data_exception); end
        checks++; if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b want 0", data_resultRDY); end
        reset = 1'b1;
    endtask

    task automatic test_mul;
        int lat;
        issue(32'd7, -32'sd6, 1'b1, 1'b0);
        wait_rdy(lat);
        checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency got %0d want 33", lat); end
        checks++; if (data_result !== 32'hFFFF_FFD6) begin errors++; $display("FAIL mul_result got %h want %h", data_result, 32'hFFFF_FFD6); end
        checks++; if (data_exception !== 1'b0) begin errors++; $display("FAIL mul_exc got %b want 0", data_exception); end
        @(posedge clock); #1;
        checks++; if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL mul_rdy_width got %b want 0", data_resultRDY); end
        repeat (3) @(posedge clock);
        #1;
        checks++; if (data_result !== 32'hFFFF_FFD6) begin errors++; $display("FAIL mul_hold got %h want %h", data_result, 32'hFFFF_FFD6); end
    endtask

    task automatic test_mul_overflow;
        int lat;
        issue(32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0);
        wait_rdy(lat);
        checks++; if (lat !== 33) begin errors++; $display("FAIL mulovf_latency got %0d want 33", lat); end
        checks++; if (data_result !== 32'h0) begin errors++; $display("FAIL mulovf_result got %h want %h", data_result, 32'h0); end
        checks++; if (data_exception !== 1'b1) begin errors++; $display("FAIL mulovf_exc got %b want 1", data_exception); end
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        wait_rdy(lat);
        checks++; if (data_result !== 32'h8000_0000) begin errors++; $display("FAIL mulmin_result got %h want %h", data_result, 32'h8000_0000); end
        checks++; if (data_exception !== 1'b1) begin errors++; $display("FAIL mulmin_exc got %b want 1", data_exception); end
    endtask

    task automatic test_div;
        int lat;
        issue(-32'sd100, 32'd7, 1'b0, 1'b1);
        wait_rdy(lat);
        checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency got %0d want 33", lat); end
        checks++; if (data_result !== 32'hFFFF_FFF2) begin errors++; $display("FAIL div_result got %h want %h", data_result, 32'hFFFF_FFF2); end
        checks++; if (data_exception !== 1'b0) begin errors++; $display("FAIL div_exc got %b want 0", data_exception); end
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
        wait_rdy(lat);
        checks++; if (data_result !== 32'h8000_0000) begin errors++; $display("FAIL divovf_result got %h want %h", data_result, 32'h8000_0000); end
        checks++; if (data_exception !== 1'b1) begin errors++; $display("FAIL divovf_exc got %b want 1", data_exception); end
    endtask

    task automatic test_reset_mid;
        int lat;
        issue(32'd9, 32'd9, 1'b1, 1'b0);
        repeat (19) @(posedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        checks++; if (data_result !== 32'h0) begin errors++; $display("FAIL rstmid_result got %h want %h", data_result, 32'h0); end
        checks++; if (data_exception !== 1'b0) begin errors++; $display("FAIL rstmid_exc got %b want 0", data_exception); end
        reset         = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd9;
        ctrl_MULT     = 1'b1;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        wait_rdy(lat);
        checks++; if (lat !== 33) begin errors++; $display("FAIL rstmid_latency got %0d want 33", lat); end
        checks++; if (data_result !== 32'd81) begin errors++; $display("FAIL rstmid_restart got %h want %h", data_result, 32'd81); end
    endtask

    task automatic test_div_zero;
        int lat;
        issue(32'd55, 32'd0, 1'b0, 1'b1);
        wait_rdy(lat);
        checks++; if (lat !== 33) begin errors++; $display("FAIL divzero_latency got %0d want 33", lat); end
        checks++; if (data_result !== 32'h0) begin errors++; $display("FAIL divzero_result got %h want %h", data_result, 32'h0); end
        checks++; if (data_exception !== 1'b1) begin errors++; $display("FAIL divzero_exc got %b want 1", data_exception); end
    endtask

    task automatic test_abort;
        int lat;
        bit early;
        early = 1'b0;
        issue(32'd1000, 32'd10, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            if (data_resultRDY) early = 1'b1;
        end
        issue(32'd3, 32'd4, 1'b1, 1'b0);
        wait_rdy(lat);
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL abort_early_rdy got %b want 0", early); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL abort_latency got %0d want 33", lat); end
        checks++; if (data_result !== 32'd12) begin errors++; $display("FAIL abort_result got %h want %h", data_result, 32'd12); end
    endtask

    task automatic test_back_to_back;
        int lat;
        issue(32'd5, 32'd6, 1'b1, 1'b0);
        wait_rdy(lat);
        checks++; if (data_result !== 32'd30) begin errors++; $display("FAIL b2b_first got %h want %h", data_result, 32'd30); end
        data_operandA = 32'd2;
        data_operandB = -32'sd3;
        ctrl_MULT     = 1'b1;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        wait_rdy(lat);
        checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency got %0d want 33", lat); end
        checks++; if (data_result !== 32'hFFFF_FFFA) begin errors++; $display("FAIL b2b_second got %h want %h", data_result, 32'hFFFF_FFFA); end
    endtask

    task automatic test_both_starts;
        int lat;
        issue(32'd3, 32'd4, 1'b1, 1'b1);
        wait_rdy(lat);
        checks++; if (data_result !== 32'd12) begin errors++; $display("FAIL both_result got %h want %h", data_result, 32'd12); end
        checks++; if (data_exception !== 1'b0) begin errors++; $display("FAIL both_exc got %b want 0", data_exception); end
    endtask

    initial begin
        reset         = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        test_reset();
        test_mul();
        test_mul_overflow();
        test_div();
        test_reset_mid();
        test_div_zero();
        test_abort();
        test_back_to_back();
        test_both_starts();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
